// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the fetch PC and issues word requests to
// instruction memory. Returned words are buffered together with their PCs and
// handed to decode. A redirect flushes everything buffered and marks every
// outstanding request as killed, so its response is dropped on return.
//
// Handshakes: every channel transfers on a cycle where valid and ready are both
// high at the rising clock edge. A producer holding valid keeps its payload
// stable until the transfer. The memory response channel has no ready: each
// response is consumed in the cycle it is presented.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-low reset
//   imem_req_*          request channel to instruction memory (addr = fetch PC)
//   imem_resp_*         in-order responses, one 32-bit word per request
//   redirect_valid/_pc  flush and restart fetch at redirect_pc (word aligned)
//   dec_*               instruction + PC presented to decode
//   inflight            number of requests accepted but not yet answered
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_resp_valid,
    input  logic [31:0]                 imem_resp_data,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic                        dec_valid,
    input  logic                        dec_ready,
    output logic [31:0]                 dec_instr,
    output logic [XLEN-1:0]             dec_pc,
    output logic [$clog2(DEPTH):0]      inflight
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // Fetch PC
    logic [XLEN-1:0] fetch_pc;

    // Tag queue: PC of every outstanding request plus a kill flag
    logic [XLEN-1:0] tag_pc [DEPTH];
    logic [DEPTH-1:0] tag_kill;
    logic [PW-1:0]   tag_wr;
    logic [PW-1:0]   tag_rd;
    logic [CW-1:0]   tag_cnt;

    // Instruction buffer
    logic [31:0]     buf_instr [DEPTH];
    logic [XLEN-1:0] buf_pc [DEPTH];
    logic [PW-1:0]   buf_wr;
    logic [PW-1:0]   buf_rd;
    logic [CW-1:0]   buf_cnt;

    logic credit_ok;
    logic req_fire;
    logic resp_take;
    logic resp_keep;
    logic dec_fire;

    // The two low bits of the redirect target are dropped on purpose.
    logic redirect_lsb_unused;
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // A buffered word plus every outstanding request each hold one credit, so
    // the buffer can never be overrun by responses already in flight. Killed
    // requests keep their credit until their response comes back.
    assign credit_ok = ({1'b0, tag_cnt} + {1'b0, buf_cnt}) < DEPTH_C;

    // Gated by reset so nothing is offered while reset is held.
    assign imem_req_valid = reset & ~redirect_valid & credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_take = imem_resp_valid & (tag_cnt != '0);
    // A response returning in the redirect cycle belongs to the old stream.
    assign resp_keep = resp_take & ~tag_kill[tag_rd] & ~redirect_valid;

    assign dec_valid = (buf_cnt != '0);
    assign dec_instr = buf_instr[buf_rd];
    assign dec_pc    = buf_pc[buf_rd];
    // The buffer is cleared on redirect, so a pop in that cycle has no effect.
    assign dec_fire  = dec_valid & dec_ready & ~redirect_valid;

    assign inflight  = tag_cnt;

    // Fetch PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    // Tag queue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_wr   <= '0;
            tag_rd   <= '0;
            tag_cnt  <= '0;
            tag_kill <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_pc[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                tag_pc[tag_wr] <= fetch_pc;
                tag_wr         <= tag_wr + 1'b1;
            end
            if (resp_take) begin
                tag_rd <= tag_rd + 1'b1;
            end
            tag_cnt <= tag_cnt + {{(CW-1){1'b0}}, req_fire}
                               - {{(CW-1){1'b0}}, resp_take};
            // Marking unused slots too is harmless: a push clears its flag.
            if (redirect_valid) begin
                tag_kill <= '1;
            end else if (req_fire) begin
                tag_kill[tag_wr] <= 1'b0;
            end
        end
    end

    // Instruction buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_wr  <= '0;
            buf_rd  <= '0;
            buf_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            buf_cnt <= '0;
            buf_rd  <= buf_wr;
        end else begin
            if (resp_keep) begin
                buf_instr[buf_wr] <= imem_resp_data;
                buf_pc[buf_wr]    <= tag_pc[tag_rd];
                buf_wr            <= buf_wr + 1'b1;
            end
            if (dec_fire) begin
                buf_rd <= buf_rd + 1'b1;
            end
            buf_cnt <= buf_cnt + {{(CW-1){1'b0}}, resp_keep}
                               - {{(CW-1){1'b0}}, dec_fire};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit (XLEN=64, RESET_PC=0x1000, DEPTH=2). A memory model
// answers accepted requests in order with an address-derived word. A queue
// level reference model predicts the request channel, the decode channel and
// the in-flight count every cycle. Directed sequences and a redirect vector
// table cover the corner cases; a randomized run covers the rest.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [63:0] RESET_PC = 64'h1000;

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DUT signals
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic [1:0]  inflight;

    fetch_unit #(.XLEN(64), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .inflight        (inflight)
    );

    // Scoreboard / reference model state
    typedef struct packed {
        logic [63:0] pc;
        logic        kill;
    } tag_t;

    tag_t        out_q[$];     // outstanding requests in issue order
    logic [95:0] exp_q[$];     // expected decode stream {instr, pc}
    logic [63:0] exp_pc;       // expected fetch PC

    // Memory environment
    logic [63:0] mem_q[$];     // addresses accepted by the DUT, not yet answered
    logic [63:0] req_log[$];   // every accepted request address
    logic [63:0] seen_q[$];    // every PC consumed by decode
    int          resp_pct  = 0;
    bit          extra_resp = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Asserts reset at the current time, checks the reset values, holds reset
    // over one rising edge and releases it on the following falling edge.
    // 'late' presents a response while reset is held.
    task automatic do_reset(input bit late);
        reset = 1'b0;
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_req_addr",  imem_req_addr, RESET_PC);
        chk("rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("rst_inflight",  64'(inflight), 64'd0);
        chk("rst_dec_instr", 64'(dec_instr), 64'd0);
        chk("rst_dec_pc",    dec_pc, 64'd0);
        out_q.delete();
        exp_q.delete();
        mem_q.delete();
        exp_pc = RESET_PC;
        if (late) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hbad0_0bad;
        end
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock cycle. Called on a falling edge with the other inputs set.
    task automatic cycle();
        logic        exp_rv;
        logic        real_resp;
        logic        c_redir;
        logic [63:0] c_rpc;
        logic        c_resp;
        logic [31:0] c_rdata;
        logic        c_drdy;
        logic        c_req;
        tag_t        t;

        real_resp = 1'b0;
        if (mem_q.size() != 0 && $urandom_range(0, 99) < resp_pct) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(mem_q[0]);
            real_resp       = 1'b1;
        end else if (extra_resp && mem_q.size() == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hdead_beef;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;

        exp_rv = !redirect_valid && (out_q.size() + exp_q.size() < DEPTH);
        chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        chk("req_addr",  imem_req_addr, exp_pc);
        chk("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("dec_pc",    dec_pc, exp_q[0][63:0]);
            chk("dec_instr", 64'(dec_instr), 64'(exp_q[0][95:64]));
        end
        chk("inflight", 64'(inflight), 64'(out_q.size()));

        // Environment bookkeeping from what the DUT actually drives
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            req_log.push_back(imem_req_addr);
        end
        if (real_resp) void'(mem_q.pop_front());
        if (dec_valid && dec_ready && !redirect_valid) seen_q.push_back(dec_pc);

        c_redir = redirect_valid;
        c_rpc   = redirect_pc;
        c_resp  = imem_resp_valid;
        c_rdata = imem_resp_data;
        c_drdy  = dec_ready;
        c_req   = exp_rv && imem_req_ready;

        @(posedge clk);
        if (c_redir) begin
            foreach (out_q[i]) out_q[i].kill = 1'b1;
            if (c_resp && out_q.size() != 0) void'(out_q.pop_front());
            exp_q.delete();
            exp_pc = c_rpc & ~64'h3;
        end else begin
            if (exp_q.size() != 0 && c_drdy) void'(exp_q.pop_front());
            if (c_resp && out_q.size() != 0) begin
                t = out_q.pop_front();
                if (!t.kill) exp_q.push_back({c_rdata, t.pc});
            end
            if (c_req) begin
                out_q.push_back({exp_pc, 1'b0});
                exp_pc = exp_pc + 64'd4;
            end
        end
        @(negedge clk);
    endtask

    // Redirect vector table
    typedef struct {
        logic [63:0] rpc;
        logic [63:0] addr0;   // fetch address right after the redirect
        logic [63:0] addr1;   // fetch address after one accepted request
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{64'h2003,                64'h2000,                64'h2004};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        tbl[3] = '{64'h7,                   64'h4,                   64'h8};
        tbl[4] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0004};

        #2;
        do_reset(1'b0);

        // Reset release, zero-wait memory, decode always ready
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        resp_pct       = 100;
        req_log.delete();
        seen_q.delete();
        #1;
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr",  imem_req_addr, 64'h1000);
        repeat (12) cycle();
        chk("req_addr_1", req_log[1], 64'h1004);
        chk("req_addr_2", req_log[2], 64'h1008);
        chk("dec_seq_0",  seen_q[0], 64'h1000);
        chk("dec_seq_1",  seen_q[1], 64'h1004);
        chk("dec_seq_2",  seen_q[2], 64'h1008);

        // Decode stalled: exactly DEPTH requests, then no more
        do_reset(1'b0);
        dec_ready = 1'b0;
        req_log.delete();
        repeat (8) cycle();
        chk("hold_req_count", 64'(req_log.size()), 64'(DEPTH));
        chk("hold_req_valid", 64'(imem_req_valid), 64'd0);
        chk("hold_dec_valid", 64'(dec_valid), 64'd1);
        chk("hold_inflight",  64'(inflight), 64'd0);
        dec_ready = 1'b1;
        seen_q.delete();
        repeat (10) cycle();
        chk("resume_seq_0", seen_q[0], 64'h1000);
        chk("resume_seq_1", seen_q[1], 64'h1004);
        chk("resume_seq_2", seen_q[2], 64'h1008);

        // Redirect with two responses outstanding
        do_reset(1'b0);
        resp_pct = 0;
        repeat (2) cycle();
        chk("pre_redir_inflight", 64'(inflight), 64'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2003;
        cycle();
        redirect_valid = 1'b0;
        chk("redir_addr",      imem_req_addr, 64'h2000);
        chk("redir_dec_valid", 64'(dec_valid), 64'd0);
        resp_pct = 100;
        seen_q.delete();
        repeat (8) cycle();
        chk("redir_first_dec", seen_q[0], 64'h2000);

        // Redirect alignment and PC wrap vectors
        for (int i = 0; i < 5; i++) begin
            do_reset(1'b0);
            imem_req_ready = 1'b0;
            redirect_valid = 1'b1;
            redirect_pc    = tbl[i].rpc;
            cycle();
            redirect_valid = 1'b0;
            chk("tbl_addr0", imem_req_addr, tbl[i].addr0);
            imem_req_ready = 1'b1;
            cycle();
            imem_req_ready = 1'b0;
            chk("tbl_addr1", imem_req_addr, tbl[i].addr1);
        end

        // Reset with one word buffered and one request outstanding
        do_reset(1'b0);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b0;
        resp_pct       = 0;
        repeat (2) cycle();
        imem_req_ready = 1'b0;
        resp_pct       = 100;
        cycle();
        resp_pct = 0;
        chk("pre_rst_dec_valid", 64'(dec_valid), 64'd1);
        chk("pre_rst_inflight",  64'(inflight), 64'd1);
        do_reset(1'b1);
        extra_resp = 1'b1;
        cycle();
        extra_resp = 1'b0;
        chk("late_resp_inflight",  64'(inflight), 64'd0);
        chk("late_resp_dec_valid", 64'(dec_valid), 64'd0);
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        #1;
        chk("restart_req_valid", 64'(imem_req_valid), 64'd1);
        chk("restart_req_addr",  imem_req_addr, RESET_PC);
        resp_pct = 100;
        repeat (4) cycle();

        // Randomized traffic against the reference model
        resp_pct = 60;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset(1'b0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            dec_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
            else
                redirect_pc = {32'($urandom), 32'($urandom)};
            extra_resp = ($urandom_range(0, 49) == 0);
            cycle();
        end
        redirect_valid = 1'b0;
        extra_resp     = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
